// File: rtl/servile_mem_sched_if.sv
// Wishbone classic bus bundle used by the servile memory scheduler.
// The master drives the request fields; the slave returns read data and ack.
interface servile_mem_sched_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, stb, output rdt, ack);
endinterface

// File: rtl/servile_mem_sched.sv
// Round-robin scheduler sharing one Wishbone memory port between ibus, dbus and aux.
// Optional stall watchdog is compiled in with SERVILE_MEM_SCHED_WATCHDOG_EN.
module servile_mem_sched #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  servile_mem_sched_if.slave  wb_ibus,
  servile_mem_sched_if.slave  wb_dbus,
  servile_mem_sched_if.slave  wb_aux,
  servile_mem_sched_if.master wb_mem,
  output logic [1:0]          o_grant,
  output logic                o_err
);

  localparam logic [1:0] GNT_IBUS = 2'd0;
  localparam logic [1:0] GNT_DBUS = 2'd1;
  localparam logic [1:0] GNT_AUX  = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

  if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("servile_mem_sched: timeout_cycles out of range 1..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] last;
  logic [2:0] req;
  logic [1:0] winner;
  logic       gnt_stb;
  logic       expire;
  logic       done;
  logic [31:0] rdt_c;

  assign req = {wb_aux.stb, wb_dbus.stb, wb_ibus.stb};

  // First requester scanning upward from the master after the previous winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] prev, input logic [2:0] r);
    int   idx;
    logic found;
    rr_pick = GNT_NONE;
    found   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(prev) + k) % 3;
      if (!found && r[idx]) begin
        rr_pick = 2'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(last, req);

  // Request mux from the granted master; the shared port is quiet while idle.
  always_comb begin
    wb_mem.adr = '0;
    wb_mem.dat = '0;
    wb_mem.sel = '0;
    wb_mem.we  = 1'b0;
    gnt_stb    = 1'b0;
    if (state == BUSY) begin
      case (o_grant)
        GNT_IBUS: begin
          wb_mem.adr = wb_ibus.adr;
          wb_mem.sel = 4'hf;
          gnt_stb    = wb_ibus.stb;
        end
        GNT_DBUS: begin
          wb_mem.adr = wb_dbus.adr;
          wb_mem.dat = wb_dbus.dat;
          wb_mem.sel = wb_dbus.sel;
          wb_mem.we  = wb_dbus.we;
          gnt_stb    = wb_dbus.stb;
        end
        GNT_AUX: begin
          wb_mem.adr = wb_aux.adr;
          wb_mem.dat = wb_aux.dat;
          wb_mem.sel = wb_aux.sel;
          wb_mem.we  = wb_aux.we;
          gnt_stb    = wb_aux.stb;
        end
        default: ;
      endcase
    end
    wb_mem.stb = gnt_stb;
  end

`ifdef SERVILE_MEM_SCHED_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(timeout_cycles - 1);

  logic [15:0] wd_cnt;

  // Counts ack-less BUSY cycles; held at zero while idle so each grant starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!wb_mem.ack) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign expire = (state == BUSY) && !wb_mem.ack && (wd_cnt == WD_LAST);
`else
  assign expire = 1'b0;
`endif

  assign o_err = expire;
  assign done  = (state == BUSY) && (wb_mem.ack || expire);

  // A watchdog-forced ack carries zero data so the master never sees stale bytes.
  assign rdt_c       = expire ? 32'h0 : wb_mem.rdt;
  assign wb_ibus.rdt = rdt_c;
  assign wb_dbus.rdt = rdt_c;
  assign wb_aux.rdt  = rdt_c;

  assign wb_ibus.ack = done && (o_grant == GNT_IBUS);
  assign wb_dbus.ack = done && (o_grant == GNT_DBUS);
  assign wb_aux.ack  = done && (o_grant == GNT_AUX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_grant <= GNT_NONE;
      last    <= GNT_AUX;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            o_grant <= winner;
            last    <= winner;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Leave on ack, watchdog expiry, or a master abandoning its request.
          if (wb_mem.ack || expire || !gnt_stb) begin
            o_grant <= GNT_NONE;
            state   <= IDLE;
          end
        end
        default: begin
          o_grant <= GNT_NONE;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servile_mem_sched.sv
// Directed self-checking bench for servile_mem_sched: per-cycle vector table
// plus hand-written sequences for writes, reset mid-transaction and the watchdog.
module tb_servile_mem_sched;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] grant;
  logic err;

  always #5 clk = ~clk;

  servile_mem_sched_if ibus ();
  servile_mem_sched_if dbus ();
  servile_mem_sched_if aux ();
  servile_mem_sched_if mem ();

  servile_mem_sched #(.timeout_cycles(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .wb_ibus (ibus),
    .wb_dbus (dbus),
    .wb_aux  (aux),
    .wb_mem  (mem),
    .o_grant (grant),
    .o_err   (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // stb = {aux, dbus, ibus}; acks = {aux, dbus, ibus}
  typedef struct {
    logic [2:0]  stb;
    logic        ack;
    logic [31:0] rdt;
    logic [1:0]  grant;
    logic        mstb;
    logic [2:0]  acks;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] stb, input logic ack, input logic [31:0] rdt,
                     input logic [1:0] g, input logic mstb, input logic [2:0] acks);
    vec_t v;
    v.stb = stb; v.ack = ack; v.rdt = rdt; v.grant = g; v.mstb = mstb; v.acks = acks;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    // All three requesting, memory acking every cycle (first ack lands in IDLE).
    for (int k = 0; k < 2; k++) begin
      add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
      if (k == 0) begin
        add(3'b111, 1'b1, 32'h0, 2'd0, 1'b1, 3'b001);
      end
    end
    vecs.delete();
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd0, 1'b1, 3'b001);
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd1, 1'b1, 3'b010);
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd2, 1'b1, 3'b100);
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd0, 1'b1, 3'b001);
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd1, 1'b1, 3'b010);
    add(3'b111, 1'b1, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b111, 1'b1, 32'h0, 2'd2, 1'b1, 3'b100);
    add(3'b000, 1'b0, 32'h0, 2'd3, 1'b0, 3'b000);
    // Single dbus read, memory acks two cycles after stb rises.
    add(3'b010, 1'b0, 32'h0,        2'd3, 1'b0, 3'b000);
    add(3'b010, 1'b0, 32'h0,        2'd1, 1'b1, 3'b000);
    add(3'b010, 1'b0, 32'h0,        2'd1, 1'b1, 3'b000);
    add(3'b010, 1'b1, 32'hDEADBEEF, 2'd1, 1'b1, 3'b010);
    add(3'b000, 1'b0, 32'h0,        2'd3, 1'b0, 3'b000);
    // Stray ack while idle goes nowhere.
    add(3'b000, 1'b1, 32'h11111111, 2'd3, 1'b0, 3'b000);
    add(3'b000, 1'b0, 32'h0,        2'd3, 1'b0, 3'b000);
    // dbus abandons its request while granted.
    add(3'b010, 1'b0, 32'h0, 2'd3, 1'b0, 3'b000);
    add(3'b000, 1'b0, 32'h0, 2'd1, 1'b0, 3'b000);
    add(3'b000, 1'b0, 32'h0, 2'd3, 1'b0, 3'b000);

    rst = 1'b1;
    ibus.adr = 32'h1000; ibus.dat = 32'h0; ibus.sel = 4'h0; ibus.we = 1'b0; ibus.stb = 1'b0;
    dbus.adr = 32'h100;  dbus.dat = 32'h55; dbus.sel = 4'hf; dbus.we = 1'b0; dbus.stb = 1'b0;
    aux.adr  = 32'h0;    aux.dat  = 32'h0;  aux.sel  = 4'h0; aux.we  = 1'b0; aux.stb  = 1'b0;
    mem.rdt  = 32'h0;    mem.ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd3);
    check("reset_mem_stb", 32'(mem.stb), 32'd0);
    check("reset_acks", 32'({aux.ack, dbus.ack, ibus.ack}), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      ibus.stb = vecs[i].stb[0];
      dbus.stb = vecs[i].stb[1];
      aux.stb  = vecs[i].stb[2];
      mem.ack  = vecs[i].ack;
      mem.rdt  = vecs[i].rdt;
      #1;
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("v%0d_mem_stb", i), 32'(mem.stb), 32'(vecs[i].mstb));
      check($sformatf("v%0d_acks", i), 32'({aux.ack, dbus.ack, ibus.ack}), 32'(vecs[i].acks));
      check($sformatf("v%0d_dbus_rdt", i), dbus.rdt, vecs[i].rdt);
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      tick();
    end

    // aux write with ibus pending; aux wins (last winner was dbus), ibus next.
    aux.adr = 32'h200; aux.dat = 32'h12345678; aux.sel = 4'b0011; aux.we = 1'b1;
    aux.stb = 1'b1; ibus.stb = 1'b1; mem.ack = 1'b0; mem.rdt = 32'h0;
    #1;
    check("idle_mem_adr", mem.adr, 32'h0);
    check("idle_mem_we", 32'(mem.we), 32'd0);
    tick();
    check("aux_grant", 32'(grant), 32'd2);
    check("aux_adr", mem.adr, 32'h200);
    check("aux_dat", mem.dat, 32'h12345678);
    check("aux_sel", 32'(mem.sel), 32'h3);
    check("aux_we", 32'(mem.we), 32'd1);
    check("aux_stb", 32'(mem.stb), 32'd1);
    mem.ack = 1'b1;
    #1;
    check("aux_ack_routing", 32'({aux.ack, dbus.ack, ibus.ack}), 32'b100);
    tick();
    aux.stb = 1'b0; mem.ack = 1'b0;
    #1;
    check("aux_then_idle", 32'(grant), 32'd3);
    tick();
    check("ibus_grant", 32'(grant), 32'd0);
    check("ibus_adr", mem.adr, 32'h1000);
    check("ibus_dat", mem.dat, 32'h0);
    check("ibus_sel", 32'(mem.sel), 32'hf);
    check("ibus_we", 32'(mem.we), 32'd0);
    mem.ack = 1'b1;
    #1;
    check("ibus_ack_routing", 32'({aux.ack, dbus.ack, ibus.ack}), 32'b001);
    tick();
    ibus.stb = 1'b0; mem.ack = 1'b0;

    // Reset in the middle of a dbus transaction; the late ack is discarded.
    dbus.stb = 1'b1;
    tick();
    tick();
    check("rst_busy_grant", 32'(grant), 32'd1);
    check("rst_busy_stb", 32'(mem.stb), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; dbus.stb = 1'b0; mem.ack = 1'b1;
    #1;
    check("rst_mid_stb", 32'(mem.stb), 32'd0);
    check("rst_mid_acks", 32'({aux.ack, dbus.ack, ibus.ack}), 32'd0);
    check("rst_mid_grant", 32'(grant), 32'd3);
    tick();
    mem.ack = 1'b0;
    check("rst_late_ack_grant", 32'(grant), 32'd3);

    // Stalled memory: ibus wins after reset, dbus waits behind it.
    mem.rdt = 32'hCAFEF00D;
    ibus.stb = 1'b1; dbus.stb = 1'b1;
    tick();
`ifdef SERVILE_MEM_SCHED_WATCHDOG_EN
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("wd_wait%0d_err", k), 32'(err), 32'd0);
      check($sformatf("wd_wait%0d_ack", k), 32'(ibus.ack), 32'd0);
      tick();
    end
    check("wd_fire_ack", 32'({aux.ack, dbus.ack, ibus.ack}), 32'b001);
    check("wd_fire_err", 32'(err), 32'd1);
    check("wd_fire_rdt", ibus.rdt, 32'h0);
    check("wd_fire_stb", 32'(mem.stb), 32'd1);
    tick();
    ibus.stb = 1'b0;
    check("wd_after_grant", 32'(grant), 32'd3);
    check("wd_after_stb", 32'(mem.stb), 32'd0);
    check("wd_after_err", 32'(err), 32'd0);
    tick();
    check("wd_next_grant", 32'(grant), 32'd1);
    // Real ack in the would-be expiry cycle wins over the watchdog.
    tick();
    tick();
    tick();
    mem.ack = 1'b1;
    #1;
    check("wd_real_ack", 32'(dbus.ack), 32'd1);
    check("wd_real_err", 32'(err), 32'd0);
    check("wd_real_rdt", dbus.rdt, 32'hCAFEF00D);
    tick();
`else
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (mem.stb !== 1'b1 || err !== 1'b0 || grant !== 2'd0) bad++;
      tick();
    end
    check("no_wd_stall_cycles", 32'(bad), 32'd0);
    mem.ack = 1'b1;
    #1;
    check("no_wd_late_ack", 32'({aux.ack, dbus.ack, ibus.ack}), 32'b001);
    tick();
`endif
    ibus.stb = 1'b0; dbus.stb = 1'b0; mem.ack = 1'b0;
    tick();
    tick();
    check("final_idle_grant", 32'(grant), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
